// File: rtl/stopwatch_bcd_core_pkg.sv
// Shared definitions for the stopwatch BCD core: FSM state encodings, the BCD
// digit limit and the prescaler width helper.
package stopwatch_bcd_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Bits needed to hold the values 0..v-1.
  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 0;
    x = v - 32'd1;
    while (x > 32'd0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_core_bcd_digit_cnt.sv
// One decimal digit of the stopwatch count: 0..9 with a wrap carry, chained
// LSB to MSB through inc/co.
module bcd_digit_cnt
  import stopwatch_bcd_core_pkg::*;
(
  input  logic       clk125MHz,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       co
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // The >= guard keeps the digit inside 0..9 even from a corrupted state.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      if (q_q >= BCD_MAX) begin
        q_d = 4'd0;
      end else begin
        q_d = q_q + 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_bcd_core.sv
// Stopwatch time base and 4-digit BCD counter (00.00..99.99) with start/stop and
// clear buttons. Optional lap-hold display is enabled by defining SW_LAP_EN.
module stopwatch_bcd_core
  import stopwatch_bcd_core_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 32'd125_000_000,
  parameter int unsigned TICK_HZ = 32'd100
) (
  input  logic       clk125MHz,
  input  logic       rst,
  input  logic       btn_startstop,
  input  logic       btn_clear,
`ifdef SW_LAP_EN
  input  logic       btn_lap,
`endif
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       running,
  output logic       ovf
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 32'd1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(32'd1);

`ifdef SW_LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] btn_raw_s;
  assign btn_raw_s = {btn_lap, btn_clear, btn_startstop};
`else
  localparam int NB = 2;
  logic [NB-1:0] btn_raw_s;
  assign btn_raw_s = {btn_clear, btn_startstop};
`endif

  logic [NB-1:0] sync1_q, sync1_d;
  logic [NB-1:0] sync2_q, sync2_d;
  logic [NB-1:0] prev_q, prev_d;
  logic [NB-1:0] edge_s;
  logic          ss_pulse_s, clr_pulse_s;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ovf_q, ovf_d;

  logic          tick_s, all9_s, sat_s, inc0_s;
  logic [3:0]    q0_s, q1_s, q2_s, q3_s;
  logic          co0_s, co1_s, co2_s, co3_unused;
  logic [15:0]   live_s, disp_s;

  always_comb begin
    sync1_d = btn_raw_s;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign edge_s      = sync2_q & ~prev_q;
  assign ss_pulse_s  = edge_s[0];
  assign clr_pulse_s = edge_s[1];

  assign live_s = {q3_s, q2_s, q1_s, q0_s};
  assign all9_s = (q0_s == BCD_MAX) && (q1_s == BCD_MAX) &&
                  (q2_s == BCD_MAX) && (q3_s == BCD_MAX);
  assign tick_s = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  assign sat_s  = tick_s & all9_s;
  assign inc0_s = tick_s & ~all9_s;

  // Clear overrides everything; a saturating tick parks the FSM in PAUSE with ovf set.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ovf_d   = ovf_q;
    if (clr_pulse_s) begin
      state_d = ST_IDLE;
      presc_d = {PW{1'b0}};
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_pulse_s && !ovf_q) state_d = ST_RUN;
          else                      state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (sat_s)           state_d = ST_PAUSE;
          else if (ss_pulse_s) state_d = ST_PAUSE;
          else                 state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (ss_pulse_s && !ovf_q) state_d = ST_RUN;
          else                      state_d = ST_PAUSE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (tick_s)                  presc_d = {PW{1'b0}};
      else if (state_q == ST_RUN)  presc_d = presc_q + PRESC_ONE;
      else                         presc_d = presc_q;
      if (sat_s) ovf_d = 1'b1;
      else       ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      sync1_q <= {NB{1'b0}};
      sync2_q <= {NB{1'b0}};
      prev_q  <= {NB{1'b0}};
      state_q <= ST_IDLE;
      presc_q <= {PW{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
    end
  end

  bcd_digit_cnt u_d0 (.clk125MHz(clk125MHz), .rst(rst), .clr(clr_pulse_s), .inc(inc0_s), .q(q0_s), .co(co0_s));
  bcd_digit_cnt u_d1 (.clk125MHz(clk125MHz), .rst(rst), .clr(clr_pulse_s), .inc(co0_s),  .q(q1_s), .co(co1_s));
  bcd_digit_cnt u_d2 (.clk125MHz(clk125MHz), .rst(rst), .clr(clr_pulse_s), .inc(co1_s),  .q(q2_s), .co(co2_s));
  bcd_digit_cnt u_d3 (.clk125MHz(clk125MHz), .rst(rst), .clr(clr_pulse_s), .inc(co2_s),  .q(q3_s), .co(co3_unused));

`ifdef SW_LAP_EN
  logic        lap_pulse_s;
  logic        lap_hold_q, lap_hold_d;
  logic [15:0] lap_q, lap_d;

  assign lap_pulse_s = edge_s[2];

  // Lap edges toggle the hold; capture only happens when starting a hold in RUN.
  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    if (clr_pulse_s) begin
      lap_hold_d = 1'b0;
    end else if (lap_pulse_s) begin
      if (lap_hold_q) begin
        lap_hold_d = 1'b0;
      end else if (state_q == ST_RUN) begin
        lap_hold_d = 1'b1;
        lap_d      = live_s;
      end else begin
        lap_hold_d = 1'b0;
      end
    end else begin
      lap_hold_d = lap_hold_q;
    end
  end

  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      lap_hold_q <= 1'b0;
      lap_q      <= 16'h0000;
    end else begin
      lap_hold_q <= lap_hold_d;
      lap_q      <= lap_d;
    end
  end

  assign disp_s = lap_hold_q ? lap_q : live_s;
`else
  assign disp_s = live_s;
`endif

  assign {d3, d2, d1, d0} = disp_s;
  assign running          = (state_q == ST_RUN);
  assign ovf              = ovf_q;

endmodule
